// File: rtl/rr_arbiter_16.sv
// Sixteen-way round-robin arbiter with a registered one-hot grant, its binary index and a valid flag.
// Optional watchdog (macro RR_ARB_TIMEOUT_EN) force-releases a holder after MAX_HOLD cycles.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid
`ifdef RR_ARB_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [15:0] mask;
  logic [15:0] elig;
  logic        force_rel;
  logic        found;
  logic [3:0]  win;

`ifdef RR_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;

  // The forced release happens on the edge that would complete MAX_HOLD grant cycles.
  assign force_rel = (state == GRANT) && req[gnt_id] && (hold_cnt == 16'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
  assign mask      = '0;
`endif

  // A force-released holder must not win the re-arbitration it triggers.
  assign elig = req & ~mask & ~(force_rel ? gnt : 16'h0000);

  always_comb begin
    found = 1'b0;
    win   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!found && elig[ptr + 4'(i)]) begin
        found = 1'b1;
        win   = ptr + 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      gnt       <= 16'h0000;
      gnt_id    <= 4'd0;
      gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      mask      <= 16'h0000;
      hold_cnt  <= 16'd0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      mask    <= (mask & req) | (force_rel ? gnt : 16'h0000);
      timeout <= force_rel;
`endif
      if (state == IDLE || !req[gnt_id] || force_rel) begin
        if (found) begin
          state     <= GRANT;
          gnt       <= 16'h0001 << win;
          gnt_id    <= win;
          gnt_valid <= 1'b1;
          ptr       <= win + 4'd1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt  <= 16'd0;
`endif
        end else begin
          state     <= IDLE;
          gnt       <= 16'h0000;
          gnt_id    <= 4'd0;
          gnt_valid <= 1'b0;
        end
      end else begin
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt <= hold_cnt + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16; expected grants are worked out by hand per vector.
// The watchdog section is built only when RR_ARB_TIMEOUT_EN is defined (MAX_HOLD = 4).
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
`ifdef RR_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  rr_arbiter_16 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
`ifdef RR_ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives a request vector, lets one rising edge pass, and returns 1 time unit later.
  task automatic applyStimulus(input logic [15:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkGrant(input string tag, input logic [3:0] id, input logic valid);
    logic [15:0] onehot;
    onehot = valid ? (16'h0001 << id) : 16'h0000;
    checkOutput({tag, "_gnt"}, gnt, onehot);
    checkOutput({tag, "_id"}, {12'h000, gnt_id}, {12'h000, id});
    checkOutput({tag, "_valid"}, {15'h0000, gnt_valid}, {15'h0000, valid});
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    #23;
    checkGrant("reset_hold", 4'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(16'hFFFF);
    checkGrant("first_grant", 4'd0, 1'b1);
    applyStimulus(16'hFFFF);
    checkGrant("hold", 4'd0, 1'b1);

    // Each holder drops only its own bit for a single edge; the grant walks 1..15 then wraps to 0.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(16'hFFFF & ~(16'h0001 << k));
      checkGrant($sformatf("rr_%0d", k), 4'((k + 1) % 16), 1'b1);
    end

    applyStimulus(16'h0008);
    checkGrant("b2b_to3", 4'd3, 1'b1);
    applyStimulus(16'h0028);
    checkGrant("b2b_hold3", 4'd3, 1'b1);
    applyStimulus(16'h0020);
    checkGrant("b2b_to5", 4'd5, 1'b1);

    applyStimulus(16'h2000);
    checkGrant("wrap_to13", 4'd13, 1'b1);
    applyStimulus(16'h0000);
    checkGrant("wrap_idle", 4'd0, 1'b0);
    applyStimulus(16'h0003);
    checkGrant("wrap_grant0", 4'd0, 1'b1);
    applyStimulus(16'h0000);
    checkGrant("wrap_idle2", 4'd0, 1'b0);
    applyStimulus(16'h0003);
    checkGrant("wrap_ptr1", 4'd1, 1'b1);

    applyStimulus(16'h0080);
    checkGrant("mid_to7", 4'd7, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkGrant("mid_async_clear", 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    applyStimulus(16'h0080);
    checkGrant("mid_regrant7", 4'd7, 1'b1);

    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    applyStimulus(16'h8001);
    checkGrant("ptr_reset", 4'd0, 1'b1);

`ifdef RR_ARB_TIMEOUT_EN
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    applyStimulus(16'h0003);
    checkGrant("to_grant0", 4'd0, 1'b1);
    checkOutput("to_pulse_c0", {15'h0000, timeout}, 16'h0000);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(16'h0003);
      checkGrant($sformatf("to_hold_%0d", c), 4'd0, 1'b1);
      checkOutput($sformatf("to_pulse_c%0d", c), {15'h0000, timeout}, 16'h0000);
    end
    applyStimulus(16'h0003);
    checkGrant("to_forced", 4'd1, 1'b1);
    checkOutput("to_pulse", {15'h0000, timeout}, 16'h0001);
    applyStimulus(16'h0003);
    checkOutput("to_pulse_end", {15'h0000, timeout}, 16'h0000);
    applyStimulus(16'h0001);
    checkGrant("to_masked", 4'd0, 1'b0);
    applyStimulus(16'h0000);
    checkGrant("to_drop", 4'd0, 1'b0);
    applyStimulus(16'h0001);
    checkGrant("to_unmasked", 4'd0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Sixteen-way round-robin arbiter that shares one downstream resource between 16 requesters. It produces a registered one-hot grant vector and its 4-bit binary index, which is the same encoding as our 16-to-4 encoder. The grant is held for as long as the holder keeps its request asserted. An optional watchdog forces release after a configurable number of cycles. The block sits between the requester array and the shared datapath, and the datapath uses `gnt_id` as its select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per holder before forced release. Range 1–65535. Used only when the timeout feature is compiled in.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `req`  in  16  : request vector, bit i belongs to requester i. Level-sensitive.
- `gnt`  out  16  : one-hot grant vector, registered. All zeros when idle.
- `gnt_id`  out  4  : binary index of the set `gnt` bit. Registered. Holds 0 when idle.
- `gnt_valid`  out  1  : high when any `gnt` bit is set. Registered.
- `timeout`  out  1  : one-cycle pulse on a forced release. Present only when the timeout feature is compiled in.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: one holder owns the resource.
- Pointer `ptr[3:0]` holds the highest-priority index. Priority search order is `ptr`, `ptr+1`, …, `ptr+15`, all modulo 16.
- IDLE → GRANT: at the edge where eligible `req` is nonzero. The first eligible index in search order becomes the holder.
  - `gnt`, `gnt_id` and `gnt_valid` update at that edge.
  - `ptr` becomes holder+1 mod 16. Index 15 wraps `ptr` to 0.
- GRANT → GRANT (hold): at an edge where `req[holder]` is 1 and no timeout occurs, all outputs are unchanged.
- GRANT release: at an edge where `req[holder]` is 0, arbitration is repeated in that same edge among the eligible requests.
  - If one is found, it is granted back-to-back with no idle cycle, and `ptr` updates.
  - If none is found, the FSM goes to IDLE and all grant outputs go to 0.
- Eligible requests are `req & ~mask`. `mask` is all zeros unless the timeout feature is compiled in.
- Simultaneous requests: only one grant is issued per edge. All other requesters wait.
- A requester that drops `req` before it is granted is simply never granted. There is no request latching.
- `gnt` is always exactly one-hot or all zeros. `gnt_id` always equals the encoded `gnt`.
- Reset, asserted at any time including mid-grant:
  - FSM goes to IDLE, `ptr` to 0, `mask` to 0, and the hold counter to 0.
  - `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0.
  - Outputs clear immediately, without waiting for a clock edge.

## Timing
- Latency from request to grant is 1 edge: `req` sampled high at edge N gives `gnt` visible after edge N.
- Release to next grant: 0 idle cycles when another eligible request is pending at the release edge.
- A holder whose `req` falls between edges N-1 and N loses `gnt` after edge N.
- Worst-case wait for a continuously requesting requester is 15 grants, each bounded by `MAX_HOLD` cycles when the timeout feature is enabled.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit hold counter resets to 0 on every new grant and increments each GRANT cycle.
  - At the edge where the counter reaches `MAX_HOLD`, the holder is force-released and re-arbitration happens as in a normal release, with the holder excluded.
  - `timeout` pulses for 1 cycle.
  - `mask[holder]` is set at the forced release. A `mask[i]` bit clears at the first edge where `req[i]` = 0.
- Undefined:
  - No counter, no `mask` (treated as 0), no `timeout` port.
  - A holder keeps the grant indefinitely.

## Test plan
- **Reset check:** hold `rst_n` = 0 with `req` = 16'hFFFF → `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0. Release reset, then after edge 1 → `gnt` = 16'h0001, `gnt_id` = 0.
- **Round robin:** keep `req` = 16'hFFFF and have each holder drop its bit for one cycle in turn → grant order 0, 1, 2, …, 15, 0. `gnt_id` increments each time and wraps after 15.
- **Back-to-back release:** holder 3, with `req` = 16'h0028. Drop `req[3]` → after the same edge `gnt` = 16'h0020, `gnt_id` = 5, and `gnt_valid` never goes low.
- **Wrap priority:** `ptr` = 14 (last grant was 13), then `req` = 16'h0003 from IDLE → grant index 0, then `ptr` = 1.
- **Timeout** (`RR_ARB_TIMEOUT_EN`, `MAX_HOLD` = 4): `req` = 16'h0003 held → grant 0 for 4 cycles, then `timeout` pulses and `gnt_id` = 1. `req[0]` stays masked until it drops for one cycle.
- **Reset mid-grant:** pull `rst_n` low while `gnt_id` = 7 → outputs are 0 asynchronously. After reset release, `req` = 16'h0080 → `gnt_id` = 7, because `ptr` restarted at 0.
